// File: rtl/switch_debouncer_pkg.sv
// Shared definitions for the push-button front end and the switch handler downstream.
// The one-hot request codes live here so both stages decode the same values.
package switch_debouncer_pkg;

    // Default geometry: three board buttons, 10 ms debounce at 50 MHz, 20 us tick.
    localparam int N_SW_DEF       = 3;
    localparam int DEB_CYCLES_DEF = 500000;
    localparam int TICK_DIV_DEF   = 1000;

    // One-hot request codes presented on the switches output (all-zero = no request).
    typedef enum logic [2:0] {
        SW_NONE = 3'b000,
        SW_0    = 3'b001,
        SW_1    = 3'b010,
        SW_2    = 3'b100
    } sw_code_e;

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch pin: two-flop synchroniser followed by a persistence counter.
// A synced level must differ from the accepted level for DEB_CYCLES consecutive
// cycles before it is accepted; any return to the accepted level restarts the count.
module switch_debounce_bit #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic clr_n,
    input  logic raw_i,
    output logic clean_o
);

    localparam int            CW       = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          clean_q;
    logic          clean_d;

    // Plain two-flop chain; nothing may sit between the flops.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive differing cycles; accept on the DEB_CYCLES-th one.
    // NOTE: defaults first so no path leaves a variable unassigned (no inferred latch).
    always_comb begin
        cnt_d   = '0;
        clean_d = clean_q;
        if (sync2_q != clean_q) begin
            if (cnt_q == CNT_LAST) begin
                clean_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter and accepted level; reset discards any debounce progress.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    assign clean_o = clean_q;

endmodule

// File: rtl/switch_debouncer.sv
// Push-button front end: per-pin debounce, press (rising edge) detection, a
// request window that is consumed on every pulse_en tick, and a priority
// encoder that presents at most one one-hot request to the switch handler.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int N_SW       = N_SW_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int TICK_DIV   = TICK_DIV_DEF
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw_clean,
    output logic [N_SW-1:0] switches,
    output logic            pulse_en
);

    localparam int            TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0]   tick_q;
    logic [TW-1:0]   tick_d;
    logic [N_SW-1:0] clean_dly_q;
    logic [N_SW-1:0] rise;
    logic [N_SW-1:0] hold_q;
    logic [N_SW-1:0] hold_d;

    for (genvar i = 0; i < N_SW; i++) begin : g_deb
        switch_debounce_bit #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk     (clk),
            .clr_n   (clr_n),
            .raw_i   (sw_raw[i]),
            .clean_o (sw_clean[i])
        );
    end

    // Tick fires while the divider sits on its last count.
    assign pulse_en = (tick_q == TICK_LAST);
    assign tick_d   = pulse_en ? '0 : tick_q + 1'b1;

    // Presses only; releases never raise a request.
    assign rise = sw_clean & ~clean_dly_q;

    // A tick consumes the window; a press on the tick cycle opens the next one.
    assign hold_d = pulse_en ? rise : (hold_q | rise);

    // Isolate the lowest set bit: bit 0 has the highest priority.
    assign switches = hold_q & (~hold_q + 1'b1);

    // Divider, edge-detect delay and request window.
    // NOTE: every flop here has an async reset; outputs are defined as soon as clr_n drops.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            tick_q      <= '0;
            clean_dly_q <= '0;
            hold_q      <= '0;
        end else begin
            tick_q      <= tick_d;
            clean_dly_q <= sw_clean;
            hold_q      <= hold_d;
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with DEB_CYCLES=4, TICK_DIV=8.
// Sample index k = number of rising edges since reset release; outputs are
// sampled on the falling edge, inputs change right after sampling.
module tb_switch_debouncer;
    import switch_debouncer_pkg::*;

    localparam int N_SW = 3;

    logic            clk = 1'b0;
    logic            clr_n = 1'b0;
    logic [N_SW-1:0] sw_raw = '0;
    logic [N_SW-1:0] sw_clean;
    logic [N_SW-1:0] switches;
    logic            pulse_en;

    int errors = 0;
    int checks = 0;
    int smp    = 0;

    switch_debouncer #(
        .N_SW       (N_SW),
        .DEB_CYCLES (4),
        .TICK_DIV   (8)
    ) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .sw_raw   (sw_raw),
        .sw_clean (sw_clean),
        .switches (switches),
        .pulse_en (pulse_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (sample %0d)", tag, obs, exp, smp);
        end
    endtask

    task automatic adv();
        @(negedge clk);
        smp++;
    endtask

    task automatic goto(input int k);
        while (smp < k) adv();
    endtask

    // Hold reset for two cycles with the given pin levels, release on a falling edge.
    task automatic do_reset(input logic [N_SW-1:0] raw);
        clr_n  = 1'b0;
        sw_raw = raw;
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        smp   = 0;
    endtask

    initial begin
        // 1. Idle after reset: ticks at k = 7, 15, 23 only.
        @(negedge clk);
        #1;
        check("rst_switches", 32'(switches), 32'(SW_NONE));
        check("rst_pulse", 32'(pulse_en), 32'd0);
        do_reset(3'b000);
        for (int k = 0; k <= 24; k++) begin
            goto(k);
            check("idle_pulse", 32'(pulse_en), ((k % 8) == 7) ? 32'd1 : 32'd0);
            check("idle_switches", 32'(switches), 32'd0);
            check("idle_clean", 32'(sw_clean), 32'd0);
        end

        // 2. Clean press on bit 0 at k=0.
        do_reset(3'b000);
        sw_raw = 3'b001;
        goto(5);  check("t2_clean_k5", 32'(sw_clean), 32'b000);
        goto(6);  check("t2_clean_k6", 32'(sw_clean), 32'b001);
                  check("t2_sw_k6", 32'(switches), 32'(SW_NONE));
        goto(7);  check("t2_sw_k7", 32'(switches), 32'(SW_0));
                  check("t2_pulse_k7", 32'(pulse_en), 32'd1);
        goto(8);  check("t2_sw_k8", 32'(switches), 32'(SW_NONE));
                  check("t2_pulse_k8", 32'(pulse_en), 32'd0);

        // 3. Bit 1 bounces 1,0,1,0 then holds 1 from k=4.
        do_reset(3'b000);
        sw_raw = 3'b010;
        goto(1); sw_raw = 3'b000;
        goto(2); sw_raw = 3'b010;
        goto(3); sw_raw = 3'b000;
        goto(4); sw_raw = 3'b010;
        goto(6);  check("t3_clean_k6", 32'(sw_clean), 32'b000);
        goto(9);  check("t3_clean_k9", 32'(sw_clean), 32'b000);
        goto(10); check("t3_clean_k10", 32'(sw_clean), 32'b010);
                  check("t3_sw_k10", 32'(switches), 32'(SW_NONE));
        goto(11); check("t3_sw_k11", 32'(switches), 32'(SW_1));
        goto(15); check("t3_sw_k15", 32'(switches), 32'(SW_1));
                  check("t3_pulse_k15", 32'(pulse_en), 32'd1);
        goto(16); check("t3_sw_k16", 32'(switches), 32'(SW_NONE));
        goto(24); check("t3_sw_k24", 32'(switches), 32'(SW_NONE));

        // 4. Bit 2 pressed at k=2, bit 1 at k=3: same window, bit 1 wins.
        do_reset(3'b000);
        goto(2); sw_raw = 3'b100;
        goto(3); sw_raw = 3'b110;
        goto(9);  check("t4_sw_k9", 32'(switches), 32'(SW_2));
        goto(10); check("t4_sw_k10", 32'(switches), 32'(SW_1));
        goto(15); check("t4_sw_k15", 32'(switches), 32'(SW_1));
                  check("t4_pulse_k15", 32'(pulse_en), 32'd1);
        goto(16); check("t4_sw_k16", 32'(switches), 32'(SW_NONE));
        goto(20); check("t4_sw_k20", 32'(switches), 32'(SW_NONE));
                  check("t4_clean_k20", 32'(sw_clean), 32'b110);

        // 5. Bit 2 press whose rise lands on the tick cycle (k=7).
        do_reset(3'b000);
        goto(1); sw_raw = 3'b100;
        goto(7);  check("t5_sw_k7", 32'(switches), 32'(SW_NONE));
                  check("t5_pulse_k7", 32'(pulse_en), 32'd1);
                  check("t5_clean_k7", 32'(sw_clean), 32'b100);
        goto(8);  check("t5_sw_k8", 32'(switches), 32'(SW_2));
        goto(15); check("t5_sw_k15", 32'(switches), 32'(SW_2));
                  check("t5_pulse_k15", 32'(pulse_en), 32'd1);
        goto(16); check("t5_sw_k16", 32'(switches), 32'(SW_NONE));

        // 6. Async reset with bit 1 held in the window and bit 0 mid-debounce.
        do_reset(3'b000);
        sw_raw = 3'b010;
        goto(3); sw_raw = 3'b011;
        goto(7);  check("t6_sw_k7", 32'(switches), 32'(SW_1));
                  check("t6_pulse_k7", 32'(pulse_en), 32'd1);
        #2;
        clr_n = 1'b0;
        #1;
        check("t6_async_sw", 32'(switches), 32'd0);
        check("t6_async_clean", 32'(sw_clean), 32'd0);
        check("t6_async_pulse", 32'(pulse_en), 32'd0);
        @(negedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        smp   = 0;
        goto(5);  check("t6_clean_k5", 32'(sw_clean), 32'b000);
        goto(6);  check("t6_clean_k6", 32'(sw_clean), 32'b011);
        goto(7);  check("t6_sw_k7b", 32'(switches), 32'(SW_0));
        goto(8);  check("t6_sw_k8b", 32'(switches), 32'(SW_NONE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
